// File: rtl/step_ctrl.sv
// step_ctrl: processor single-step / free-run controller.
//
// Generates a one-cycle step_o enable. In free-run mode (mode_i = 0) a step
// is issued for every rising edge of the slow tick_i. In manual mode
// (mode_i = 1) a step is issued once per debounced press of btn_i.
// All raw inputs pass through 2-flop synchronizers before use.
//
// Optional feature: define STEP_COUNT_EN to build a wrapping step counter on
// count_o. Without it, count_o is tied to zero and no counter flops exist.
//
// Parameters:
//   DEBOUNCE_CYCLES  clk_i cycles btn_i must be stable before a level change
//   CNT_W            width of count_o
// Ports:
//   clk_i      system clock, rising edge
//   rst_ni     asynchronous active-low reset
//   tick_i     slow divided clock, asynchronous to clk_i
//   btn_i      raw step pushbutton, active-high, bouncing
//   mode_i     raw slide switch: 0 = free-run, 1 = manual single-step
//   step_o     one-cycle processor-advance enable
//   btn_lvl_o  debounced button level
//   count_o    number of step_o pulses issued (STEP_COUNT_EN only)
module step_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tick_i,
    input  logic             btn_i,
    input  logic             mode_i,
    output logic             step_o,
    output logic             btn_lvl_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned   DW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] CNT_MAX  = DW'(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_e;

    // Synchronizers and edge-detect history
    logic [1:0] tick_sync_q, btn_sync_q, mode_sync_q;
    logic       tick_prev_q, mode_prev_q;
    logic [1:0] vld_q;      // fills with ones once the synchronizers hold real samples
    logic       armed_q;    // a genuine low tick has been seen since reset

    logic       tick_s, btn_s, mode_s;
    logic       tick_rise, mode_chg;

    state_e        state_q, state_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d, deb_cnt_inc;
    logic          press_acc;
    logic          step_q, step_d;

    assign tick_s = tick_sync_q[1];
    assign btn_s  = btn_sync_q[1];
    assign mode_s = mode_sync_q[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tick_sync_q <= '0;
            btn_sync_q  <= '0;
            mode_sync_q <= '0;
            tick_prev_q <= 1'b0;
            mode_prev_q <= 1'b0;
            vld_q       <= '0;
            armed_q     <= 1'b0;
        end else begin
            tick_sync_q <= {tick_sync_q[0], tick_i};
            btn_sync_q  <= {btn_sync_q[0], btn_i};
            mode_sync_q <= {mode_sync_q[0], mode_i};
            tick_prev_q <= tick_s;
            mode_prev_q <= mode_s;
            vld_q       <= {vld_q[0], 1'b1};
            armed_q     <= armed_q | (vld_q[1] & ~tick_s);
        end
    end

    // A tick already high at reset release looks like a 0->1 edge against the
    // reset value of tick_prev_q; armed_q withholds edges until a real low.
    assign tick_rise = tick_s & ~tick_prev_q & armed_q;
    assign mode_chg  = mode_s ^ mode_prev_q;

    // Debounce FSM: state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            deb_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign deb_cnt_inc = (deb_cnt_q == CNT_MAX) ? deb_cnt_q : deb_cnt_q + DW'(1);

    // Debounce FSM: next state. The sample that leaves IDLE/PRESSED counts as
    // the first of the DEBOUNCE_CYCLES stable samples.
    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        press_acc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d   = PRESS_WAIT;
                    deb_cnt_d = DW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q >= CNT_LAST) begin
                    state_d   = PRESSED;
                    deb_cnt_d = '0;
                    press_acc = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_inc;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_d   = RELEASE_WAIT;
                    deb_cnt_d = DW'(1);
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d   = PRESSED;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q >= CNT_LAST) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_inc;
                end
            end
            default: begin
                state_d   = IDLE;
                deb_cnt_d = '0;
            end
        endcase
    end

    // Debounce FSM: outputs
    always_comb begin
        btn_lvl_o = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
    end

    // Step source selected by synchronized mode; any edge in a mode-change
    // cycle is dropped rather than deferred.
    always_comb begin
        step_d = 1'b0;
        if (!mode_chg && !step_q) begin
            step_d = mode_s ? press_acc : tick_rise;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step_d;
        end
    end

    assign step_o = step_q;

`ifdef STEP_COUNT_EN
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (step_q) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count_o = count_q;
`else
    assign count_o = '0;
`endif

endmodule

// File: tb/tb_step_ctrl.sv
// tb_step_ctrl: randomized scoreboard bench for step_ctrl.
// A reference model observes the inputs at each clock edge, applies the
// synchronizer latency, run-length debounce and mode rules, and queues the
// expected step cycles and per-cycle button level / count. A separate monitor
// compares the DUT against those queues on the falling clock edge.
module tb_step_ctrl;

    localparam int unsigned DEB = 8;
    localparam int unsigned CW  = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick  = 1'b0;
    logic          btn   = 1'b0;
    logic          mode  = 1'b0;
    logic          step;
    logic          lvl;
    logic [CW-1:0] cnt;

    always #5 clk = ~clk;

    step_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (CW)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .tick_i   (tick),
        .btn_i    (btn),
        .mode_i   (mode),
        .step_o   (step),
        .btn_lvl_o(lvl),
        .count_o  (cnt)
    );

    typedef struct {
        bit          lvl;
        bit [CW-1:0] cnt;
    } stat_t;

    int unsigned checks = 0;
    int unsigned passes = 0;
    int          cyc    = 0;    // clock edges since reset release
    int          dut_steps = 0;

    // Model state: input values seen 0..3 edges ago
    bit          th[4];
    bit          mh[4];
    bit          bh[3];
    bit          lvl_m;
    int          run_m;
    int unsigned cnt_m;
    int          exp_steps[$];
    stat_t       exp_stat[$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    function automatic void reset_model();
        cyc   = 0;
        lvl_m = 1'b0;
        run_m = 0;
        cnt_m = 0;
        for (int i = 0; i < 4; i++) begin
            th[i] = 1'b0;
            mh[i] = 1'b0;
        end
        for (int i = 0; i < 3; i++) bh[i] = 1'b0;
        exp_steps.delete();
        exp_stat.delete();
    endfunction

    // Reference model
    initial begin
        bit press, exp_step;
        forever begin
            @(posedge clk);
            if (rst_n) begin
                cyc++;
                for (int i = 3; i > 0; i--) begin
                    th[i] = th[i-1];
                    mh[i] = mh[i-1];
                end
                bh[2] = bh[1];
                bh[1] = bh[0];
                th[0] = tick;
                mh[0] = mode;
                bh[0] = btn;

                // Debounce: level flips after DEB consecutive opposite samples
                press = 1'b0;
                if (bh[2] != lvl_m) begin
                    run_m++;
                    if (run_m == int'(DEB)) begin
                        lvl_m = ~lvl_m;
                        run_m = 0;
                        press = lvl_m;
                    end
                end else begin
                    run_m = 0;
                end

                exp_step = 1'b0;
                if (mh[2] == mh[3]) begin
                    if (!mh[2] && cyc >= 4 && th[2] && !th[3]) exp_step = 1'b1;
                    if (mh[2] && press) exp_step = 1'b1;
                end

`ifdef STEP_COUNT_EN
                exp_stat.push_back('{lvl_m, CW'(cnt_m)});
`else
                exp_stat.push_back('{lvl_m, '0});
`endif
                if (exp_step) begin
                    exp_steps.push_back(cyc);
                    cnt_m++;
                end
            end
        end
    end

    // Monitor
    initial begin
        stat_t s;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (exp_steps.size() > 0 && exp_steps[0] < cyc) begin
                    checks++;
                    $display("FAIL step_missing: step_o=0 at cycle %0d, expected 1", exp_steps[0]);
                    void'(exp_steps.pop_front());
                end
                if (step) begin
                    dut_steps++;
                    checks++;
                    if (exp_steps.size() > 0 && exp_steps[0] == cyc) begin
                        passes++;
                        void'(exp_steps.pop_front());
                    end else begin
                        $display("FAIL step_unexpected: step_o=1 at cycle %0d, expected 0", cyc);
                    end
                end
                if (exp_stat.size() > 0) begin
                    s = exp_stat.pop_front();
                    check("btn_lvl", 32'(lvl), 32'(s.lvl));
                    check("count", 32'(cnt), 32'(s.cnt));
                end
            end
        end
    end

    task automatic wait_cyc(int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ticks(int unsigned n, int unsigned half);
        repeat (n) begin
            tick = 1'b1;
            wait_cyc(half);
            tick = 1'b0;
            wait_cyc(half);
        end
    endtask

    task automatic do_reset(string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "_step"}, 32'(step), 32'd0);
        check({tag, "_lvl"}, 32'(lvl), 32'd0);
        check({tag, "_count"}, 32'(cnt), 32'd0);
        reset_model();
        wait_cyc(3);
        #2;
        rst_n = 1'b1;
    endtask

    int s0;

    initial begin
        reset_model();
        wait_cyc(3);
        check("reset_step", 32'(step), 32'd0);
        check("reset_lvl", 32'(lvl), 32'd0);
        check("reset_count", 32'(cnt), 32'd0);
        #2;
        rst_n = 1'b1;

        // Free-run: 5 ticks, period 20
        mode = 1'b0;
        wait_cyc(10);
        s0 = dut_steps;
        ticks(5, 10);
        wait_cyc(10);
        #3;
        check("freerun_steps", 32'(dut_steps - s0), 32'd5);
`ifdef STEP_COUNT_EN
        check("freerun_count", 32'(cnt), 32'd5);
`else
        check("freerun_count", 32'(cnt), 32'd0);
`endif

        // Bounce: toggle every 3 cycles for 30 cycles, then hold high
        mode = 1'b1;
        wait_cyc(10);
        s0 = dut_steps;
        repeat (10) begin
            btn = ~btn;
            wait_cyc(3);
        end
        btn = 1'b1;
        wait_cyc(20);
        btn = 1'b0;
        wait_cyc(20);
        #3;
        check("bounce_steps", 32'(dut_steps - s0), 32'd1);

        // Hold: 100 cycles high gives a single step
        s0 = dut_steps;
        btn = 1'b1;
        wait_cyc(100);
        btn = 1'b0;
        wait_cyc(30);
        #3;
        check("hold_steps", 32'(dut_steps - s0), 32'd1);

        // Mode isolation
        s0 = dut_steps;
        ticks(4, 5);
        wait_cyc(5);
        #3;
        check("manual_ignores_tick", 32'(dut_steps - s0), 32'd0);
        mode = 1'b0;
        wait_cyc(10);
        s0 = dut_steps;
        repeat (3) begin
            btn = 1'b1;
            wait_cyc(20);
            btn = 1'b0;
            wait_cyc(20);
        end
        #3;
        check("freerun_ignores_btn", 32'(dut_steps - s0), 32'd0);

        // Reset mid-PRESS_WAIT with tick high
        btn = 1'b1;
        wait_cyc(4);
        tick = 1'b1;
        wait_cyc(1);
        do_reset("rst_presswait");
        s0 = dut_steps;
        wait_cyc(20);
        #3;
        check("no_step_tick_high_at_release", 32'(dut_steps - s0), 32'd0);
        tick = 1'b0;
        wait_cyc(5);
        tick = 1'b1;
        wait_cyc(10);
        #3;
        check("step_after_new_tick_rise", 32'(dut_steps - s0), 32'd1);
        tick = 1'b0;
        btn = 1'b0;
        wait_cyc(20);

        // Reset while PRESSED (level high, counter non-zero)
        btn = 1'b1;
        wait_cyc(20);
        #3;
        check("pressed_before_reset", 32'(lvl), 32'd1);
        do_reset("rst_pressed");
        btn = 1'b0;
        wait_cyc(20);

        // Counter wrap: 17 ticks on a 4-bit counter
        ticks(17, 4);
        wait_cyc(10);
        #3;
`ifdef STEP_COUNT_EN
        check("wrap_count", 32'(cnt), 32'd1);
`else
        check("wrap_count", 32'(cnt), 32'd0);
`endif

        // Random traffic with alternating bouncy and calm button segments
        for (int seg = 0; seg < 6; seg++) begin
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(5) == 0) tick = ~tick;
                if ((seg % 2) == 0) begin
                    if ($urandom_range(2) == 0) btn = ~btn;
                end else begin
                    if ($urandom_range(29) == 0) btn = ~btn;
                end
                if ($urandom_range(119) == 0) mode = ~mode;
                wait_cyc(1);
            end
        end

        tick = 1'b0;
        btn  = 1'b0;
        wait_cyc(30);
        #3;
        check("queue_drained", 32'(exp_steps.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
